// File: rtl/dcram_fill_wr.sv
// Data-cache RAM fill writer: stages a critical-word-first 4-word line fill in a
// small FIFO and issues one halfword-masked 64-bit RAM write per buffered word.
module dcram_fill_wr #(
    parameter int DC_MSB     = 13,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fill_req,
    input  logic [DC_MSB:0] fill_addr,
    input  logic            fill_way,
    input  logic [1:0]      crit_word,
    input  logic [31:0]     biu_data,
    input  logic            biu_valid,
    output logic            fill_rdy,
    input  logic            cpu_hold,
    input  logic            abort,
    output logic [DC_MSB:0] addr,
    output logic [1:0]      bank_sel,
    output logic            bypass,
    output logic [3:0]      we,
    output logic [63:0]     data_in,
    output logic            fill_done,
    output logic            busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0]   PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [DC_MSB:0] LINE_MASK = {{(DC_MSB - 3){1'b1}}, 4'b0000};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DC_MSB:0] base_q, base_d;
    logic            way_q, way_d;
    logic [1:0]      crit_q, crit_d;
    logic [2:0]      acc_cnt_q, acc_cnt_d;
    logic [2:0]      wr_cnt_q, wr_cnt_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fifo_data_q [FIFO_DEPTH];
    logic [1:0]      fifo_idx_q  [FIFO_DEPTH];

    logic [DC_MSB:0] addr_q, addr_d;
    logic [1:0]      bank_sel_q, bank_sel_d;
    logic            bypass_q, bypass_d;
    logic [3:0]      we_q, we_d;
    logic [63:0]     data_q, data_d;
    logic            fill_rdy_q, fill_rdy_d;
    logic            fill_done_q, fill_done_d;
    logic            busy_q, busy_d;

    logic            push_s, pop_s, flush_s;
    logic [1:0]      push_idx_s, head_idx_s;
    logic [31:0]     head_data_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign push_idx_s  = crit_q + acc_cnt_q[1:0];
    assign head_idx_s  = fifo_idx_q[rd_ptr_q];
    assign head_data_s = fifo_data_q[rd_ptr_q];

    // Fill sequencing: state, latched line context, accept/write counters
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        way_d     = way_q;
        crit_d    = crit_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        flush_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d   = FILL;
                    base_d    = fill_addr & LINE_MASK;
                    way_d     = fill_way;
                    crit_d    = crit_word;
                    acc_cnt_d = 3'd0;
                    wr_cnt_d  = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                // abort outranks push, pop and the move to DONE
                if (abort) begin
                    state_d = IDLE;
                    flush_s = 1'b1;
                end else begin
                    push_s = biu_valid & fill_rdy_q;
                    pop_s  = (count_q != '0) & ~cpu_hold;
                    if (push_s) begin
                        acc_cnt_d = acc_cnt_q + 3'd1;
                    end else begin
                        acc_cnt_d = acc_cnt_q;
                    end
                    if (pop_s) begin
                        wr_cnt_d = wr_cnt_q + 3'd1;
                        state_d  = (wr_cnt_q == 3'd3) ? DONE : FILL;
                    end else begin
                        wr_cnt_d = wr_cnt_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                flush_s = 1'b1;
            end
            default: begin
                state_d = IDLE;
                flush_s = 1'b1;
            end
        endcase
        if (flush_s) begin
            acc_cnt_d = 3'd0;
            wr_cnt_d  = 3'd0;
        end else begin
            acc_cnt_d = acc_cnt_d;
        end
    end

    // Staging FIFO pointers and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // RAM write port and handshake outputs; addr/data_in hold when no write issues
    always_comb begin
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = 4'b0000;
        bank_sel_d  = 2'b00;
        bypass_d    = 1'b0;
        if (pop_s) begin
            addr_d     = base_q | {{(DC_MSB - 3){1'b0}}, head_idx_s[1], 3'b000};
            data_d     = {head_data_s, head_data_s};
            we_d       = head_idx_s[0] ? 4'b0011 : 4'b1100;
            bank_sel_d = way_q ? 2'b10 : 2'b01;
            bypass_d   = (wr_cnt_q == 3'd0);
        end else begin
            we_d = 4'b0000;
        end
        fill_done_d = (state_q == DONE) & ~abort;
        fill_rdy_d  = (state_d == FILL) && (count_d < CNT_FULL) && (acc_cnt_d < 3'd4);
        busy_d      = (state_d != IDLE);
    end

    // FIFO storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= 32'd0;
                fifo_idx_q[i]  <= 2'd0;
            end
        end else if (push_s) begin
            fifo_data_q[wr_ptr_q] <= biu_data;
            fifo_idx_q[wr_ptr_q]  <= push_idx_s;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            way_q       <= 1'b0;
            crit_q      <= 2'd0;
            acc_cnt_q   <= 3'd0;
            wr_cnt_q    <= 3'd0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            bank_sel_q  <= 2'b00;
            bypass_q    <= 1'b0;
            we_q        <= 4'b0000;
            data_q      <= 64'd0;
            fill_rdy_q  <= 1'b0;
            fill_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            way_q       <= way_d;
            crit_q      <= crit_d;
            acc_cnt_q   <= acc_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            bank_sel_q  <= bank_sel_d;
            bypass_q    <= bypass_d;
            we_q        <= we_d;
            data_q      <= data_d;
            fill_rdy_q  <= fill_rdy_d;
            fill_done_q <= fill_done_d;
            busy_q      <= busy_d;
        end
    end

    assign addr      = addr_q;
    assign bank_sel  = bank_sel_q;
    assign bypass    = bypass_q;
    assign we        = we_q;
    assign data_in   = data_q;
    assign fill_rdy  = fill_rdy_q;
    assign fill_done = fill_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dcram_fill_wr.sv
// Bench for dcram_fill_wr: directed scenarios plus randomized fills, checked against
// an expected-write list built from line address, way, critical word and fill data.
module tb_dcram_fill_wr;
    localparam int DC_MSB = 13;

    logic            clk       = 1'b0;
    logic            reset     = 1'b1;
    logic            fill_req  = 1'b0;
    logic [DC_MSB:0] fill_addr = '0;
    logic            fill_way  = 1'b0;
    logic [1:0]      crit_word = 2'd0;
    logic [31:0]     biu_data  = 32'd0;
    logic            biu_valid = 1'b0;
    logic            cpu_hold  = 1'b0;
    logic            abort     = 1'b0;
    logic            fill_rdy;
    logic [DC_MSB:0] addr;
    logic [1:0]      bank_sel;
    logic            bypass;
    logic [3:0]      we;
    logic [63:0]     data_in;
    logic            fill_done;
    logic            busy;

    always #5 clk = ~clk;

    dcram_fill_wr #(.DC_MSB(DC_MSB), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .fill_req(fill_req), .fill_addr(fill_addr),
        .fill_way(fill_way), .crit_word(crit_word), .biu_data(biu_data),
        .biu_valid(biu_valid), .fill_rdy(fill_rdy), .cpu_hold(cpu_hold), .abort(abort),
        .addr(addr), .bank_sel(bank_sel), .bypass(bypass), .we(we), .data_in(data_in),
        .fill_done(fill_done), .busy(busy)
    );

    typedef struct packed {
        logic [13:0] a;
        logic [3:0]  w;
        logic [63:0] d;
        logic        b;
        logic [1:0]  bk;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    logic [31:0] words [4];
    logic [13:0] t1_addr [4] = '{14'h0120, 14'h0120, 14'h0128, 14'h0128};
    logic [3:0]  t1_we   [4] = '{4'b1100, 4'b0011, 4'b1100, 4'b0011};
    int n_checks = 0, n_fail = 0, n_done = 0, n_writes = 0, cyc = 0;
    int last_wr_cyc = 0, done_cyc = 0, acc = 0, hold_pct = 0, valid_pct = 100;
    int fill_d0 = 0, fill_w0 = 0, dsave = 0;
    bit feeding = 1'b0, extra_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_addr"}, 64'(addr), 64'd0);
        chk({pfx, "_bank_sel"}, 64'(bank_sel), 64'd0);
        chk({pfx, "_bypass"}, 64'(bypass), 64'd0);
        chk({pfx, "_we"}, 64'(we), 64'd0);
        chk({pfx, "_data_in"}, data_in, 64'd0);
        chk({pfx, "_fill_rdy"}, 64'(fill_rdy), 64'd0);
        chk({pfx, "_fill_done"}, 64'(fill_done), 64'd0);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Expected writes: k-th delivered word goes to idx (crit+k) mod 4 of the line.
    task automatic plan_fill(input logic [13:0] line, input logic way, input logic [1:0] crit);
        int  idx;
        wr_t e;
        for (int k = 0; k < 4; k++) begin
            idx  = (int'(crit) + k) % 4;
            e.a  = 14'((int'(line) / 16) * 16 + (idx / 2) * 8);
            e.w  = (idx % 2 == 1) ? 4'b0011 : 4'b1100;
            e.d  = {words[k[1:0]], words[k[1:0]]};
            e.b  = (k == 0);
            e.bk = way ? 2'b10 : 2'b01;
            exp_q.push_back(e);
        end
    endtask

    task automatic cycle();
        logic hs;
        wr_t  e;
        wr_t  o;
        hs = biu_valid && fill_rdy;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            acc++;
            if (acc == 4) chk("rdy_after_4th", 64'(fill_rdy), 64'd0);
        end
        if (fill_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (we !== 4'b0000) begin
            n_writes++;
            last_wr_cyc = cyc;
            o = {addr, we, data_in, bypass, bank_sel};
            obs_q.push_back(o);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(we), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(addr), 64'(e.a));
                chk("wr_we", 64'(we), 64'(e.w));
                chk("wr_data", data_in, e.d);
                chk("wr_bypass", 64'(bypass), 64'(e.b));
                chk("wr_bank_sel", 64'(bank_sel), 64'(e.bk));
            end
        end
        if (feeding) begin
            if (!(biu_valid && !hs)) begin
                if (acc < 4) biu_valid = (int'($urandom_range(0, 99)) < valid_pct);
                else         biu_valid = extra_valid;
            end
            biu_data = words[acc[1:0]];
            if (hold_pct > 0) cpu_hold = (int'($urandom_range(0, 99)) < hold_pct);
        end
    endtask

    task automatic start_fill(input logic [13:0] line, input logic way, input logic [1:0] crit);
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        exp_q.delete();
        obs_q.delete();
        plan_fill(line, way, crit);
        acc       = 0;
        fill_d0   = n_done;
        fill_w0   = n_writes;
        fill_addr = line;
        fill_way  = way;
        crit_word = crit;
        fill_req  = 1'b1;
        biu_valid = 1'b0;
        cycle();
        fill_req  = 1'b0;
        feeding   = 1'b1;
        biu_valid = 1'b1;
        biu_data  = words[0];
    endtask

    task automatic finish_fill(input bit poke);
        int n;
        n = 0;
        while (n_done == fill_d0 && n < 300) begin
            if (poke && n == 1) begin
                fill_req  = 1'b1;
                fill_addr = 14'h2AA0;
                crit_word = 2'd3;
            end else begin
                fill_req = 1'b0;
            end
            cycle();
            n++;
        end
        fill_req = 1'b0;
        chk("fill_timeout", 64'(n_done != fill_d0), 64'd1);
        chk("writes_left", 64'(exp_q.size()), 64'd0);
        chk("write_count", 64'(n_writes - fill_w0), 64'd4);
        chk("done_latency", 64'(done_cyc - last_wr_cyc), 64'd1);
        feeding   = 1'b0;
        biu_valid = 1'b0;
        cpu_hold  = 1'b0;
        cycle();
        cycle();
        chk("done_once", 64'(n_done - fill_d0), 64'd1);
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b0;
        cycle();

        // back-to-back fill, crit 0, way 0
        start_fill(14'h0120, 1'b0, 2'd0);
        finish_fill(1'b0);
        chk("t1_obs_count", 64'(obs_q.size()), 64'd4);
        for (int k = 0; k < obs_q.size(); k++) begin
            chk("t1_addr", 64'(obs_q[k].a), 64'(t1_addr[k[1:0]]));
            chk("t1_we", 64'(obs_q[k].w), 64'(t1_we[k[1:0]]));
            chk("t1_bank", 64'(obs_q[k].bk), 64'd1);
        end

        // wrapped critical word on way 1
        start_fill(14'h3FF0, 1'b1, 2'd3);
        finish_fill(1'b0);
        if (obs_q.size() == 4) begin
            chk("wrap_addr0", 64'(obs_q[0].a), 64'h3FF8);
            chk("wrap_we0", 64'(obs_q[0].w), 64'h3);
            chk("wrap_byp0", 64'(obs_q[0].b), 64'd1);
            chk("wrap_bank0", 64'(obs_q[0].bk), 64'd2);
            for (int k = 1; k < 4; k++) chk("wrap_byp_rest", 64'(obs_q[k].b), 64'd0);
        end

        // cpu_hold for 6 cycles: writes stall, two words buffered, then drain
        cpu_hold = 1'b1;
        start_fill(14'h0040, 1'b0, 2'd2);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("hold_no_we", 64'(we), 64'd0);
        end
        chk("hold_rdy_low", 64'(fill_rdy), 64'd0);
        chk("hold_buffered", 64'(acc), 64'd2);
        cpu_hold = 1'b0;
        finish_fill(1'b0);

        // abort with two words buffered
        cpu_hold = 1'b1;
        start_fill(14'h0880, 1'b0, 2'd2);
        cycle();
        cycle();
        chk("abort_buffered", 64'(acc), 64'd2);
        feeding = 1'b0;
        abort   = 1'b1;
        cycle();
        abort     = 1'b0;
        biu_valid = 1'b0;
        cpu_hold  = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_we", 64'(we), 64'd0);
        chk("abort_rdy", 64'(fill_rdy), 64'd0);
        exp_q.delete();
        dsave = n_done;
        cycle();
        cycle();
        chk("abort_no_done", 64'(n_done - dsave), 64'd0);
        start_fill(14'h0880, 1'b1, 2'd1);
        finish_fill(1'b0);
        if (obs_q.size() > 0) chk("post_abort_bypass", 64'(obs_q[0].b), 64'd1);

        // asynchronous reset in the middle of a fill
        start_fill(14'h1000, 1'b1, 2'd1);
        cycle();
        cycle();
        cycle();
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        feeding   = 1'b0;
        fill_req  = 1'b1;
        biu_valid = 1'b1;
        cycle();
        cycle();
        chk("rst_hold_busy", 64'(busy), 64'd0);
        chk("rst_hold_rdy", 64'(fill_rdy), 64'd0);
        reset     = 1'b0;
        fill_req  = 1'b0;
        biu_valid = 1'b0;
        exp_q.delete();
        cycle();
        chk("post_rst_idle", 64'(busy), 64'd0);

        // re-request during FILL and a fifth valid word are both ignored
        extra_valid = 1'b1;
        start_fill(14'h0200, 1'b0, 2'd1);
        finish_fill(1'b1);
        extra_valid = 1'b0;

        // randomized fills with random stalls and valid gaps
        hold_pct  = 30;
        valid_pct = 70;
        for (int f = 0; f < 12; f++) begin
            start_fill(14'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)));
            finish_fill(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcram_fill_wr.md
Name: dcram_fill_wr

Overview:
- Write-side initiator for the data cache RAM; it drives the RAM's addr, bank_sel, bypass, we and data_in inputs.
- Accepts a 4-word (16-byte) line fill from the bus interface, delivered critical-word-first, and buffers it in a 2-entry FIFO.
- Issues one registered 64-bit RAM write per word into the selected way.
- Yields to CPU accesses through cpu_hold and supports abort of an in-flight fill.

Parameters:
- DC_MSB, 13: MSB of the RAM byte address; matches `dc_msb.
- FIFO_DEPTH, 2: word staging entries. Fixed at 2; the design is not verified for other values.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- fill_req  in  1  start a line fill; sampled only in IDLE.
- fill_addr  in  DC_MSB+1  line byte address; bits [3:0] ignored and forced to 0.
- fill_way  in  1  target way: 0 selects bank_sel 2'b01, 1 selects 2'b10.
- crit_word  in  2  index of the first word delivered.
- biu_data  in  32  fill word.
- biu_valid  in  1  fill word valid; the BIU holds data until it is accepted.
- fill_rdy  out  1  word accepted when biu_valid & fill_rdy.
- cpu_hold  in  1  CPU owns the RAM this cycle; no fill write may issue.
- abort  in  1  synchronous cancel of the current fill.
- addr  out  DC_MSB+1  RAM byte address of the doubleword being written.
- bank_sel  out  2  one-hot way select; 0 when idle.
- bypass  out  1  high on the write carrying the critical word.
- we  out  4  halfword write enables; we[3] covers data_in[63:48].
- data_in  out  64  RAM write data.
- fill_done  out  1  one-cycle pulse when the line is fully written.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE, FIFO empty, counters 0. All outputs 0: addr, bank_sel, bypass, we, data_in, fill_rdy, fill_done, busy.
- States:
  - IDLE: fill_req=1 latches line base = {fill_addr[DC_MSB:4],4'b0}, way, crit_word. Sets acc_cnt=0 and wr_cnt=0, then moves to FILL.
  - FILL: remains until 4 writes have been issued, or abort.
  - DONE: one cycle, fill_done=1, then IDLE.
- fill_req in FILL or DONE is ignored.
- Accept side:
  - fill_rdy is registered: 1 in FILL when (FIFO count after this edge) < 2 and acc_cnt < 4; otherwise 0.
  - There is no combinational path from a same-cycle pop to fill_rdy.
  - On accept, push {biu_data, idx}, where idx = (crit_word + acc_cnt) mod 4, then increment acc_cnt.
  - Index wrap example: crit_word=3 gives the order 3,0,1,2.
- Issue side:
  - When the FIFO is non-empty and cpu_hold=0, pop one entry; outputs are registered and valid the next cycle.
  - addr = base | {idx[1],3'b000}.
  - Even idx: data_in = {word,word}, we=4'b1100. Odd idx: data_in = {word,word}, we=4'b0011.
  - bank_sel = way ? 2'b10 : 2'b01.
  - bypass=1 only when wr_cnt==0 (the critical word). Increment wr_cnt.
- Cycles with no pop: we=0, bank_sel=0, bypass=0; addr and data_in hold their last values.
- Latency: a word accepted at edge N is written to the RAM earliest at the outputs after edge N+1, provided cpu_hold=0.
- Pop on the 4th write: the next state is DONE, and fill_done is asserted the cycle after the last write is on the outputs.
- cpu_hold=1 stalls pops only; accepts continue until the FIFO is full (count 2).
- Simultaneous push and pop in one cycle: count is unchanged.
- abort=1 in FILL or DONE:
  - Next edge gives state=IDLE, FIFO flushed, counters 0, we=0, fill_rdy=0, and no fill_done.
  - abort has priority over push, pop and the transition to DONE.
  - abort in IDLE has no effect.
- fill_done and abort on the same edge: abort wins, so no fill_done pulse.

Test Plan:
- Back-to-back fill, addr=0x0120, way=0, crit=0, data A0..A3, biu_valid continuous, cpu_hold=0 -> four writes:
  - addr 0x120 we=1100 bypass=1, addr 0x120 we=0011, addr 0x128 we=1100, addr 0x128 we=0011.
  - bank_sel=01 on all four; fill_done one cycle after the 4th write.
- Wrap, crit=3, way=1, addr=0x3FF0 -> idx order 3,0,1,2:
  - First write addr 0x3FF8 we=0011 bypass=1 bank_sel=10; the remaining three have bypass=0.
- cpu_hold=1 for 6 cycles mid-fill -> we=0 throughout; fill_rdy drops after 2 buffered words; on release the buffered words are written in order and no data is lost.
- abort with 2 words buffered -> next cycle state=IDLE, we=0, busy=0, no fill_done; a following fill_req starts cleanly with bypass on its first write.
- reset asserted asynchronously mid-FILL -> all outputs 0 immediately, without waiting for a clock edge; fill_req or biu_valid during reset is ignored.
- fill_req pulsed again during FILL, and a 5th biu_valid after 4 accepts -> both ignored; fill_rdy=0 after the 4th accept; exactly 4 writes issued.
